// File: rtl/mem16_responder.sv
// Halfword memory responder: accepts read/write strobes, stores halfwords in an
// internal array, and returns read data after READ_LATENCY with a valid pulse.
module mem16_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [15:0]           mem_wdata,
  output logic                  mem_ready,
  output logic [15:0]           mem_rdata,
  output logic                  mem_rdata_valid,
  output logic                  mem_write_ack,
  output logic                  mem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      count_reg, count_next;
  logic [15:0]     pending_reg;
  logic [15:0]     mem [0:DEPTH-1];

  logic            accept;
  logic            in_range;
  logic            rd_req;
  logic            wr_commit;
  logic            err_req;
  logic [31:0]     addr_ext;
  logic [IDX_W-1:0] idx;
  logic [15:0]     rd_word;

  assign addr_ext  = 32'(mem_address);
  assign in_range  = addr_ext < DEPTH_U;
  assign idx       = mem_address[IDX_W-1:0];
  assign accept    = mem_enable && mem_ready;
  // Out-of-range reads still follow the read path so the requester gets a valid pulse.
  assign rd_req    = accept && mem_read_enable && !mem_write_enable;
  assign wr_commit = accept && mem_write_enable && !mem_read_enable && in_range;
  assign err_req   = accept && ((mem_read_enable == mem_write_enable) || !in_range);
  assign rd_word   = in_range ? mem[idx] : 16'h0000;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (rd_req && (READ_LATENCY > 1)) begin
          state_next = RD_WAIT;
          count_next = 4'(READ_LATENCY - 1);
        end
      end
      RD_WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_ready = (state_reg == IDLE);
  end

  // Registered response pulses and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg     <= 16'h0000;
      mem_rdata       <= 16'h0000;
      mem_rdata_valid <= 1'b0;
      mem_write_ack   <= 1'b0;
      mem_error       <= 1'b0;
    end else begin
      mem_write_ack   <= wr_commit;
      mem_error       <= err_req;
      mem_rdata_valid <= 1'b0;
      if (rd_req) begin
        if (READ_LATENCY == 1) begin
          mem_rdata       <= rd_word;
          mem_rdata_valid <= 1'b1;
        end else begin
          pending_reg <= rd_word;
        end
      end
      if (state_reg == RD_WAIT && count_reg == 4'd1) begin
        mem_rdata       <= pending_reg;
        mem_rdata_valid <= 1'b1;
      end
    end
  end

  // Array storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[idx] <= mem_wdata;
  end

endmodule

// File: doc/mem16_responder.md
Name: mem16_responder

Overview:
Memory-side responder for the 16-bit data memory port driven by the CPU's memory control FSM. It accepts enable, read and write strobes with a halfword address and write data, and stores halfwords in an internal array. Read data is returned after a configurable latency with a valid pulse, and a ready signal stalls the requester while a read is outstanding. The port has no byte enables: byte and halfword merging (read-modify-write) is the requester's job. Word accesses arrive as two separate halfword transactions.

Parameters:
ADDR_WIDTH, 8, halfword address width
DEPTH, 256, number of implemented halfwords; must satisfy DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 2, cycles from read-accept edge to rdata_valid; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_enable  input  1  request strobe
mem_read_enable  input  1  read request, qualified by mem_enable
mem_write_enable  input  1  write request, qualified by mem_enable
mem_address  input  ADDR_WIDTH  halfword address
mem_wdata  input  16  write data
mem_ready  output  1  high when a request can be accepted
mem_rdata  output  16  read data; holds its last value between reads
mem_rdata_valid  output  1  one-cycle pulse, read data valid
mem_write_ack  output  1  one-cycle pulse, write committed
mem_error  output  1  one-cycle pulse, request rejected

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE and the latency counter clears to 0.
  - mem_ready=1; mem_rdata=16'h0000; mem_rdata_valid=0; mem_write_ack=0; mem_error=0.
  - Array contents are not reset.
- Accept condition: rising edge with mem_enable=1 and mem_ready=1.
  - Requests presented while mem_ready=0 are ignored silently, with no error.
- Request decode at accept:
  - Legal write: wr=1, rd=0, address < DEPTH.
  - Legal read: rd=1, wr=0, address < DEPTH.
  - Error: rd=wr (both set or both clear), or address >= DEPTH.
- Write:
  - mem[address] <= mem_wdata at the accept edge.
  - mem_write_ack=1 for the following cycle.
  - mem_ready stays 1, so back-to-back writes are allowed every cycle.
- Read:
  - Array is sampled at the accept edge.
  - mem_rdata is updated and mem_rdata_valid=1 for exactly one cycle, starting READ_LATENCY edges after accept.
- FSM states:
  - IDLE: mem_ready=1.
  - RD_WAIT: mem_ready=0; entered on read accept only when READ_LATENCY>1; loads counter=READ_LATENCY-1.
  - RD_WAIT decrements the counter each edge; at counter==1 it returns to IDLE, and that edge drives mem_rdata/mem_rdata_valid.
  - So mem_ready re-asserts in the same cycle rdata_valid is high, and a new request is acceptable at the end of that cycle.
  - READ_LATENCY=1: FSM never leaves IDLE; valid appears the cycle after accept; back-to-back reads are allowed.
- Error:
  - No array access takes place.
  - mem_error=1 for the following cycle.
  - An out-of-range read additionally produces mem_rdata_valid=1 with mem_rdata=16'h0000 at normal read latency, so the requester FSM never hangs.
  - An illegal strobe combination (rd=wr) produces only mem_error.
- Pulses:
  - write_ack, rdata_valid and error are registered and last one cycle each.
  - write_ack and rdata_valid are never high in the same cycle.
- Reset mid-read: the outstanding read is discarded; no rdata_valid is ever produced for it.
- Latency counter width: 4 bits.

Test Plan:
1. Reset, write 16'hBEEF at address 8'h10, then read 8'h10 with READ_LATENCY=2 -> write_ack one cycle after write; ready low for 1 cycle; rdata=16'hBEEF with valid exactly 2 edges after read accept.
2. Writes to 8'h00..8'h03 on 4 consecutive cycles (data 16'h0001..16'h0004), then reads of all four -> 4 back-to-back write_acks; reads return 16'h0001..16'h0004 in order; each read accept occurs only when ready=1.
3. mem_enable with rd=1 and wr=1 at address 8'h05 holding 16'h1234 -> mem_error pulse; no rdata_valid; a subsequent read of 8'h05 returns 16'h1234, unchanged.
4. DEPTH=200: read 8'hF0, then write 16'hAAAA to 8'hF0 -> read gives mem_error plus rdata_valid with 16'h0000; write gives mem_error with no write_ack; array unchanged.
5. READ_LATENCY=4: read issued, reset asserted 2 cycles later -> outputs go to reset values immediately, asynchronously; no rdata_valid afterwards; ready=1.
6. READ_LATENCY=1: reads of 8'h01 and 8'h02 on consecutive cycles -> ready constantly 1; two consecutive rdata_valid cycles with the correct data.
